// File: rtl/mcpu_irq_ctrl_pkg.sv
// Shared constants and helpers for the main-CPU interrupt controller.
package mcpu_irq_pkg;

  // Byte placed on the bus for an IM1 acknowledge (RST 38h opcode).
  localparam logic [7:0] IM1_VEC = 8'hFF;

  // IM2 vector of source idx: base + idx*step, wrapped to a byte.
  function automatic logic [7:0] vec_of(input logic [7:0] base,
                                        input int unsigned step,
                                        input int unsigned idx);
    logic [31:0] sum;
    sum = 32'(base) + step * idx;
    return sum[7:0];
  endfunction

  // Index width for NSRC sources, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mcpu_irq_ctrl_if.sv
// CPU-side bus and interrupt lines of the interrupt controller.
//
// Acknowledge protocol: the CPU signals an interrupt acknowledge by holding
// cpu_io and cpu_m1 high together. The first clock with both high is the
// ack start; the vector is presented on cpu_di from that edge and held until
// either strobe drops. There is no back-pressure: the controller always
// answers in the same cycle the ack starts.
interface mcpu_irq_ctrl_if #(
  parameter int NSRC = 4,
  parameter int AW   = 2
);
  logic [7:0]      cpu_din;
  logic            cpu_rd;
  logic            cpu_io;
  logic            cpu_m1;
  logic [NSRC-1:0] src_n;
  logic [NSRC-1:0] irq_en;
  logic            nmi_src_n;
  logic [7:0]      cpu_di;
  logic            int_n;
  logic            nmi_n;
  logic [NSRC-1:0] irq_pending;
  logic [AW-1:0]   ack_id;
  logic            ack_stb;

  // Controller side
  modport slave (
    input  cpu_din, cpu_rd, cpu_io, cpu_m1, src_n, irq_en, nmi_src_n,
    output cpu_di, int_n, nmi_n, irq_pending, ack_id, ack_stb
  );

  // CPU wrapper / decoder side
  modport master (
    output cpu_din, cpu_rd, cpu_io, cpu_m1, src_n, irq_en, nmi_src_n,
    input  cpu_di, int_n, nmi_n, irq_pending, ack_id, ack_stb
  );
endinterface

// File: rtl/mcpu_irq_ctrl_prio.sv
// Lowest-index-wins priority encoder over the active interrupt vector.
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int AW = 2
) (
  input  logic [N-1:0]  i_req,
  output logic          o_any,
  output logic [AW-1:0] o_idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_any = |i_req;
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = AW'(i);
    end
  end

endmodule

// File: rtl/mcpu_irq_ctrl.sv
// Interrupt / data-in controller for the tv80 main CPU: source capture,
// pending bits, ack vector injection, CPU read-data latch and NMI pulse.
module mcpu_irq_ctrl
  import mcpu_irq_pkg::*;
#(
  parameter int              NSRC       = 4,
  parameter bit              IM2        = 1'b1,
  parameter logic [7:0]      VEC_BASE   = 8'h90,
  parameter int unsigned     VEC_STEP   = 2,
  parameter logic [7:0]      SPUR_VEC   = 8'hFF,
  parameter logic [NSRC-1:0] LEVEL_MASK = '0,
  parameter int              NMI_LEN    = 4
) (
  input  logic            clk_sys,
  input  logic            reset,
  mcpu_irq_ctrl_if.slave  bus
);

  localparam int AW = clog2w(NSRC);
  localparam int CW = $clog2(NMI_LEN + 1);

  logic [NSRC-1:0] r_src_q;
  logic [NSRC-1:0] r_edge_pend;
  logic            r_iack_q;
  logic            r_int_n;
  logic [7:0]      r_vec_q;
  logic [7:0]      r_di;
  logic [AW-1:0]   r_ack_id;
  logic            r_ack_stb;
  logic            r_nmi_q;
  logic [CW-1:0]   r_nmi_cnt;
  logic            r_nmi_n;

  logic [NSRC-1:0] w_pending;
  logic [NSRC-1:0] w_active;
  logic [NSRC-1:0] w_set;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_win_oh;
  logic            w_any;
  logic [AW-1:0]   w_winner;
  logic            w_iack;
  logic            w_ack_start;
  logic [7:0]      w_vec;
  logic            w_nmi_fall;
  logic [CW-1:0]   w_nmi_cnt_nxt;

  // Level sources mirror the registered request; edge sources use the sticky bit.
  assign w_pending   = (r_edge_pend & ~LEVEL_MASK) | (~r_src_q & LEVEL_MASK);
  assign w_active    = w_pending & bus.irq_en;
  assign w_set       = r_src_q & ~bus.src_n & ~LEVEL_MASK;
  assign w_iack      = bus.cpu_io & bus.cpu_m1;
  assign w_ack_start = w_iack & ~r_iack_q;
  assign w_win_oh    = NSRC'(1) << w_winner;
  assign w_clr       = (w_ack_start && w_any) ? (w_win_oh & ~LEVEL_MASK) : '0;
  assign w_nmi_fall  = r_nmi_q & ~bus.nmi_src_n;

  irq_prio_enc #(.N(NSRC), .AW(AW)) u_prio (
    .i_req (w_active),
    .o_any (w_any),
    .o_idx (w_winner)
  );

  // Byte to inject on this ack: per-source IM2 vector, RST 38h, or spurious.
  always_comb begin
    w_vec = SPUR_VEC;
    if (w_any) w_vec = IM2 ? vec_of(VEC_BASE, VEC_STEP, 32'(w_winner)) : IM1_VEC;
  end

  // NMI down-counter: a new falling edge only loads when the counter is idle.
  always_comb begin
    w_nmi_cnt_nxt = r_nmi_cnt;
    if (r_nmi_cnt != '0)  w_nmi_cnt_nxt = r_nmi_cnt - CW'(1);
    else if (w_nmi_fall)  w_nmi_cnt_nxt = CW'(NMI_LEN);
  end

  // Request capture and sticky edge pending bits (a new edge beats an ack clear).
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_src_q     <= '1;
      r_edge_pend <= '0;
    end else begin
      r_src_q     <= bus.src_n;
      r_edge_pend <= ((r_edge_pend & ~w_clr) | w_set) & ~LEVEL_MASK;
    end
  end

  // Ack sequencing: INT line, injected vector, ack id and strobe.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_iack_q  <= 1'b0;
      r_int_n   <= 1'b1;
      r_vec_q   <= 8'hFF;
      r_ack_id  <= '0;
      r_ack_stb <= 1'b0;
    end else begin
      r_iack_q  <= w_iack;
      r_int_n   <= w_iack ? 1'b1 : ~|w_active;
      r_ack_stb <= w_ack_start & w_any;
      if (w_ack_start) begin
        r_vec_q <= w_vec;
        if (w_any) r_ack_id <= w_winner;
      end
    end
  end

  // CPU read-data latch: ack vector first, then held vector, then bus data.
  always_ff @(posedge clk_sys) begin
    if (reset)            r_di <= 8'h00;
    else if (w_ack_start) r_di <= w_vec;
    else if (w_iack)      r_di <= r_vec_q;
    else if (bus.cpu_rd)  r_di <= bus.cpu_din;
  end

  // NMI edge detect and registered pulse output.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_nmi_q   <= 1'b1;
      r_nmi_cnt <= '0;
      r_nmi_n   <= 1'b1;
    end else begin
      r_nmi_q   <= bus.nmi_src_n;
      r_nmi_cnt <= w_nmi_cnt_nxt;
      r_nmi_n   <= (w_nmi_cnt_nxt == '0);
    end
  end

  assign bus.cpu_di      = r_di;
  assign bus.int_n       = r_int_n;
  assign bus.nmi_n       = r_nmi_n;
  assign bus.irq_pending = w_pending;
  assign bus.ack_id      = r_ack_id;
  assign bus.ack_stb     = r_ack_stb;

endmodule

// File: doc/mcpu_irq_ctrl.md
# mcpu_irq_ctrl

Parametrised interrupt and data-in controller for the tv80-based main CPU wrappers. Collects NSRC interrupt sources (edge or level per source), prioritises them, drives the CPU's int_n/nmi_n, and owns the CPU's read-data latch. During an interrupt acknowledge it injects a per-source IM2 vector, or RST 38h in IM1. This replaces per-game hard-wired vector patches in CPU wrappers.

## Interface
- NSRC, 4: number of maskable sources; index 0 is highest priority.
- IM2, 1: 1 = inject IM2 vector; 0 = inject 8'hFF (RST 38h) on every ack.
- VEC_BASE, 8'h90: IM2 vector of source 0.
- VEC_STEP, 2: vector increment per source index; vector = VEC_BASE + i*VEC_STEP, mod 256.
- SPUR_VEC, 8'hFF: byte injected when an ack finds nothing pending/enabled.
- LEVEL_MASK, 0: NSRC-bit mask; bit i = 1 makes source i level-sensitive.
- NMI_LEN, 4: nmi_n low-pulse length in clk_sys cycles, ≥1.
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_din  in  8  bus read data from the address decoder.
- cpu_rd  in  1  CPU read strobe, active high.
- cpu_io  in  1  CPU IORQ, active high.
- cpu_m1  in  1  CPU M1, active high.
- src_n  in  NSRC  interrupt requests, active low, synchronous to clk_sys.
- irq_en  in  NSRC  per-source enable.
- nmi_src_n  in  1  NMI request, active low, falling-edge triggered.
- cpu_di  out  8  registered data to the CPU di port.
- int_n  out  1  registered CPU INT, active low.
- nmi_n  out  1  registered CPU NMI, active low.
- irq_pending  out  NSRC  pending vector, before masking.
- ack_id  out  clog2(NSRC), min 1  index of the last acknowledged source.
- ack_stb  out  1  one-cycle pulse per acknowledged, non-spurious interrupt.

## Operation
- Source capture:
  - src_q <= src_n each cycle.
  - Edge source i: pending[i] set when src_q[i] & ~src_n[i]. Cleared only by its own ack.
  - Level source i: pending[i] = ~src_q[i]. An ack does not clear it.
- Masking: active = pending & irq_en. Disabling a source holds its pending bit; re-enabling re-raises int_n.
- Priority: winner = lowest index in active. Purely combinational, via irq_prio_enc.
- int_n: registered ~|active. Forced to 1 at the ack-start edge and held at 1 while iack stays asserted.
- Ack detection:
  - iack = cpu_io & cpu_m1; iack_q registered.
  - Ack start = iack & ~iack_q. At that edge:
    - vec_q <= IM2 ? VEC_BASE + winner*VEC_STEP : 8'hFF.
    - ack_id <= winner; ack_stb <= 1.
    - Edge-type winner's pending bit is cleared.
  - If active == 0 at ack start: vec_q <= SPUR_VEC; no ack_stb; ack_id unchanged.
- cpu_di priority:
  - Ack-start edge: load the vector directly.
  - iack held: hold vec_q.
  - Else if cpu_rd: latch cpu_din.
  - Else hold.
- Simultaneous set and ack-clear on the same edge-type bit: set wins, bit stays pending.
- NMI:
  - Falling edge of nmi_src_n (registered compare) loads an NMI_LEN down-counter.
  - nmi_n = 0 while the counter is nonzero.
  - Edges while the counter is nonzero are ignored.

## Timing
- Reset values:
  - cpu_di = 8'h00; int_n = 1; nmi_n = 1; irq_pending = 0; ack_id = 0; ack_stb = 0; vec_q = 8'hFF.
  - src_q = all ones; nmi_q = 1; iack_q = 0; NMI counter = 0.
- Edge-source latency: src_n sampled low at edge k (high at k-1) → pending at k → int_n low at k+1.
- Ack: ack-start edge k → cpu_di = vector, ack_stb = 1, int_n = 1, all at k; ack_stb low again at k+1.
- Return of int_n: if another source is active, int_n falls one edge after iack deasserts.
- NMI: nmi_src_n falls before edge k → nmi_n low from k for exactly NMI_LEN cycles.
- Reset mid-ack clears all state. If iack is still high at the first post-reset edge, it is a new ack start; with nothing pending it injects SPUR_VEC.

## Structure
- Package mcpu_irq_pkg holds:
  - IM1_VEC = 8'hFF.
  - Vector function vec_of(base, step, idx), truncated to 8 bits.
  - clog2 helper for the ack_id width.
- Sub-module irq_prio_enc: parametrised NSRC-bit lowest-index priority encoder; outputs any and idx.
- Top level holds capture, pending, ack sequencing, data latch and NMI counter.

## Test plan
- Edge IRQ, IM2: src_n[2] falls; pulse iack for 3 cycles → int_n low 2 edges after the fall; cpu_di = 8'h94 during iack; ack_stb once with ack_id = 2; pending[2] cleared; int_n stays 1.
- Priority: src 1 and 3 fall together, two acks → vectors 8'h92 then 8'h96; int_n re-asserts one edge after the first iack ends.
- Mask and spurious:
  - irq_en[0] = 0, src 0 falls → int_n stays 1, irq_pending[0] = 1.
  - Enable → int_n low next edge.
  - Ack with nothing active → cpu_di = 8'hFF, no ack_stb.
- Level source (LEVEL_MASK = 4'b0001), IM2 = 0: src_n[0] held low through ack → vector 8'hFF; int_n low again one edge after iack ends; released → pending clears.
- Data latch: cpu_rd with cpu_din = 8'h5A → cpu_di = 8'h5A, held after cpu_rd drops; same-cycle set/clear race on src 2 leaves it pending.
- NMI and reset:
  - nmi_src_n falls → nmi_n low exactly 4 cycles; a second fall mid-pulse is ignored.
  - Reset asserted mid-ack → all outputs return to reset values next edge.
